// File: rtl/pong_display_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : pong_display_seq_if
// Brief    : Game events in and display qualifiers out for the Pong sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface pong_display_seq_if;
    logic       frame_start;
    logic       start_btn;
    logic       p1_scored;
    logic       p2_scored;
    logic       game_over;
    logic       ball_show;
    logic       paddles_show;
    logic [1:0] lives_show;
    logic [5:0] border_color;
    logic       serve_go;
    logic [2:0] state;

    modport master (
        output frame_start, start_btn, p1_scored, p2_scored, game_over,
        input  ball_show, paddles_show, lives_show, border_color, serve_go, state
    );

    modport slave (
        input  frame_start, start_btn, p1_scored, p2_scored, game_over,
        output ball_show, paddles_show, lives_show, border_color, serve_go, state
    );
endinterface
`default_nettype wire

// File: rtl/pong_display_seq.sv
`default_nettype none
// ============================================================================
// Module   : pong_display_seq
// Brief    : Game-phase sequencer driving ball/paddle/lives/border qualifiers.
// Revision : 1.0 - initial release
// ============================================================================
module pong_display_seq #(
    parameter int unsigned SERVE_FRAMES  = 60,
    parameter int unsigned FLASH_FRAMES  = 32,
    parameter int unsigned BLINK_LOG2    = 3,
    parameter logic [5:0]  BORDER_NORMAL = 6'b111111,
    parameter logic [5:0]  BORDER_FLASH  = 6'b110000
) (
    input  wire logic          clk,
    input  wire logic          reset,
    pong_display_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_ATTRACT     = 3'd0,
        ST_SERVE       = 3'd1,
        ST_PLAY        = 3'd2,
        ST_SCORE_FLASH = 3'd3,
        ST_GAMEOVER    = 3'd4
    } state_t;

    localparam logic [6:0] c_SERVE_LAST = 7'(SERVE_FRAMES - 1);
    localparam logic [6:0] c_FLASH_LAST = 7'(FLASH_FRAMES - 1);
    localparam logic [6:0] c_CNT_MAX    = 7'd127;

    state_t     r_state, w_state_nxt;
    logic [6:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_mask, w_mask_nxt;
    logic       r_ball, w_ball_nxt;
    logic       r_paddles;
    logic [1:0] r_lives, w_lives_nxt;
    logic [5:0] r_border, w_border_nxt;
    logic       r_go, w_go_nxt;
    logic       w_blink;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_ATTRACT;
            r_cnt     <= 7'd0;
            r_mask    <= 2'b00;
            r_ball    <= 1'b0;
            r_paddles <= 1'b1;
            r_lives   <= 2'b11;
            r_border  <= BORDER_NORMAL;
            r_go      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_mask    <= w_mask_nxt;
            r_ball    <= w_ball_nxt;
            r_paddles <= 1'b1;
            r_lives   <= w_lives_nxt;
            r_border  <= w_border_nxt;
            r_go      <= w_go_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mask_nxt   = r_mask;
        w_go_nxt     = 1'b0;
        w_cnt_nxt    = r_cnt;
        w_blink      = 1'b0;
        w_ball_nxt   = 1'b0;
        w_lives_nxt  = 2'b11;
        w_border_nxt = BORDER_NORMAL;

        case (r_state)
            ST_ATTRACT: begin
                if (bus.start_btn) w_state_nxt = ST_SERVE;
            end
            ST_SERVE: begin
                if (bus.frame_start && (r_cnt == c_SERVE_LAST)) begin
                    w_state_nxt = ST_PLAY;
                    w_go_nxt    = 1'b1;
                end
            end
            ST_PLAY: begin
                // Game over outranks any point scored in the same cycle.
                if (bus.game_over) begin
                    w_state_nxt = ST_GAMEOVER;
                end else if (bus.p1_scored || bus.p2_scored) begin
                    w_state_nxt = ST_SCORE_FLASH;
                    w_mask_nxt  = {bus.p1_scored, bus.p2_scored};
                end
            end
            ST_SCORE_FLASH: begin
                if (bus.frame_start && (r_cnt == c_FLASH_LAST)) begin
                    w_state_nxt = bus.game_over ? ST_GAMEOVER : ST_SERVE;
                    w_mask_nxt  = 2'b00;
                end
            end
            ST_GAMEOVER: begin
                if (bus.start_btn) w_state_nxt = ST_SERVE;
            end
            default: begin
                w_state_nxt = ST_ATTRACT;
                w_mask_nxt  = 2'b00;
            end
        endcase

        if (w_state_nxt != r_state)
            w_cnt_nxt = 7'd0;
        else if (bus.frame_start && (r_cnt != c_CNT_MAX))
            w_cnt_nxt = r_cnt + 7'd1;

        // Outputs are decoded from the next-cycle view so they line up with the registered state.
        w_blink = w_cnt_nxt[BLINK_LOG2];
        case (w_state_nxt)
            ST_SERVE: w_ball_nxt = w_blink;
            ST_PLAY:  w_ball_nxt = 1'b1;
            ST_SCORE_FLASH: begin
                w_lives_nxt[1] = w_mask_nxt[1] ? w_blink : 1'b1;
                w_lives_nxt[0] = w_mask_nxt[0] ? w_blink : 1'b1;
                w_border_nxt   = w_blink ? BORDER_NORMAL : BORDER_FLASH;
            end
            ST_GAMEOVER: w_border_nxt = BORDER_FLASH;
            default: ;
        endcase
    end

    assign bus.ball_show    = r_ball;
    assign bus.paddles_show = r_paddles;
    assign bus.lives_show   = r_lives;
    assign bus.border_color = r_border;
    assign bus.serve_go     = r_go;
    assign bus.state        = r_state;

endmodule
`default_nettype wire

// File: doc/pong_display_seq.md
PONG_DISPLAY_SEQ -- requirements
Module: pong_display_seq

Interface
REQ-001 SHALL have parameter SERVE_FRAMES, default 60: frames the ball blinks before play resumes (range 2..127).
REQ-002 SHALL have parameter FLASH_FRAMES, default 32: frames of the score-flash effect (range 2..127).
REQ-003 SHALL have parameter BLINK_LOG2, default 3: blink half-period is 2^BLINK_LOG2 frames (range 0..5).
REQ-004 SHALL have parameter BORDER_NORMAL, default 6'b111111: border colour outside flash effects.
REQ-005 SHALL have parameter BORDER_FLASH, default 6'b110000: border colour during flash and game-over.
REQ-006 SHALL have port clk  input  1  single clock for the block.
REQ-007 SHALL have port reset  input  1  reset; asynchronous, active-high.
REQ-008 SHALL have port frame_start  input  1  one-cycle pulse at the start of each video frame.
REQ-009 SHALL have port start_btn  input  1  one-cycle start/restart request, synchronised upstream.
REQ-010 SHALL have port p1_scored, p2_scored  input  1 each  one-cycle point events.
REQ-011 SHALL have port game_over  input  1  level; a player has no lives left.
REQ-012 SHALL have port ball_show  output  1  qualifies the ball layer enable in the video mux.
REQ-013 SHALL have port paddles_show  output  1  qualifies both paddle layer enables.
REQ-014 SHALL have port lives_show  output  2  bit0 p1 lives layer, bit1 p2 lives layer.
REQ-015 SHALL have port border_color  output  6  colour fed to the mux border input.
REQ-016 SHALL have port serve_go  output  1  one-cycle pulse releasing the ball logic.
REQ-017 SHALL have port state  output  3  current state code, for debug.

Function
REQ-018 SHALL implement states ATTRACT=0, SERVE=1, PLAY=2, SCORE_FLASH=3, GAMEOVER=4; codes 5-7 SHALL go to ATTRACT next cycle.
REQ-019 SHALL keep a 7-bit frame counter, cleared on every state transition, incremented on frame_start, saturating at 127.
REQ-020 SHALL register all outputs; an output reflects an input event one clk after the sampling edge.
REQ-021 ATTRACT: ball_show 0, paddles_show 1, lives_show 2'b11, border BORDER_NORMAL; start_btn -> SERVE.
REQ-022 SERVE: ball_show = counter[BLINK_LOG2], paddles 1, lives 2'b11, border normal; on frame_start with counter == SERVE_FRAMES-1 -> PLAY and serve_go pulses exactly 1 cycle.
REQ-023 PLAY: ball_show 1, paddles 1, lives 2'b11, border normal.
REQ-024 PLAY: game_over high -> GAMEOVER, taking priority over simultaneous score events.
REQ-025 PLAY: p1_scored or p2_scored -> SCORE_FLASH, latching a 2-bit conceder mask (p1_scored sets bit1, p2_scored sets bit0); simultaneous events set both bits.
REQ-026 SCORE_FLASH: ball_show 0; border = BORDER_FLASH when counter[BLINK_LOG2]=0, else BORDER_NORMAL; lives_show bits in the conceder mask = counter[BLINK_LOG2], other bits 1.
REQ-027 SCORE_FLASH: on frame_start with counter == FLASH_FRAMES-1 -> GAMEOVER if game_over high, else SERVE; conceder mask cleared on exit.
REQ-028 Score events SHALL be ignored outside PLAY; start_btn SHALL be ignored outside ATTRACT and GAMEOVER.
REQ-029 GAMEOVER: ball_show 0, paddles 1, lives 2'b11, border BORDER_FLASH steady; start_btn -> SERVE.
REQ-030 frame_start and a transition in the same cycle: transition wins and the counter SHALL read 0 in the new state.

Reset
REQ-031 While reset is high: state ATTRACT, counter 0, conceder mask 0, ball_show 0, paddles_show 1, lives_show 2'b11, border_color BORDER_NORMAL, serve_go 0.
REQ-032 Reset asserted mid-state (including during a serve_go pulse) SHALL take effect immediately without waiting for clk.

Verification
REQ-033 Reset, start_btn, then 60 frame_start pulses -> state 1 then 2, serve_go high exactly one cycle, ball_show toggles every 8 frames during SERVE.
REQ-034 In PLAY, pulse p2_scored -> state 3, lives_show[0] blinks (period 16 frames), lives_show[1]=1, border alternates 6'b110000/6'b111111; after 32 frames -> state 1.
REQ-035 In PLAY, p1_scored and p2_scored in the same cycle -> both lives_show bits blink together.
REQ-036 In PLAY, game_over and p1_scored in the same cycle -> state 4, border 6'b110000 steady, ball_show 0; start_btn -> state 1.
REQ-037 Score pulses in ATTRACT/SERVE and start_btn in PLAY -> no state change.
REQ-038 Assert reset mid-SCORE_FLASH -> all outputs at reset values asynchronously, before the next clk edge.
